// File: rtl/noc_port_arbiter_pkg.sv
// Shared definitions for the NoC output-port arbiter: parameter defaults,
// grant index width and the arbiter state encoding.
package noc_port_arbiter_pkg;

  localparam int unsigned NUM_REQ_DEF = 5;
  localparam int unsigned FLIT_W_DEF  = 16;
  localparam int unsigned CREDITS_DEF = 4;
  localparam int unsigned GRANT_W     = 3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/noc_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request searching upward
// from (last_grant+1) mod NUM_REQ, wrapping to index 0.
module rr_picker
  import noc_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GRANT_W-1:0] last_grant_i,
  output logic [GRANT_W-1:0] grant_o,
  output logic               any_req_o
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  int unsigned idx;

  always_comb begin
    grant_o   = '0;
    any_req_o = 1'b0;
    idx       = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_grant_i) + k) % NUM_REQ;
      if (!any_req_o && req_i[idx[IW-1:0]]) begin
        any_req_o = 1'b1;
        grant_o   = GRANT_W'(idx);
      end
    end
  end

endmodule

// File: rtl/noc_port_arbiter.sv
// Wormhole output-port arbiter: round-robin grant locked for a whole packet,
// credit-based flow control toward the downstream buffer, registered output.
module noc_port_arbiter
  import noc_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned FLIT_W  = FLIT_W_DEF,
  parameter int unsigned CREDITS = CREDITS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*FLIT_W-1:0] req_flit,
  input  logic [NUM_REQ-1:0]        req_tail,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [FLIT_W-1:0]         out_flit,
  output logic                      out_tail,
  input  logic                      credit_in,
  output logic [2:0]                grant_id,
  output logic                      locked,
  output logic                      credit_err
);

  localparam int unsigned CW = $clog2(CREDITS + 1);

  arb_state_e         state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] last_q, last_d;
  logic [CW-1:0]      credit_q, credit_d;
  logic               err_q, err_d;
  logic               ov_q, ov_d;
  logic [FLIT_W-1:0]  flit_q, flit_d;
  logic               tail_q, tail_d;

  logic [GRANT_W-1:0] pick;
  logic               any_req;
  logic               sel_valid, sel_tail, accept;
  logic [FLIT_W-1:0]  sel_flit;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i        (req_valid),
    .last_grant_i (last_q),
    .grant_o      (pick),
    .any_req_o    (any_req)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_tail  = 1'b0;
    sel_flit  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GRANT_W'(i)) begin
        sel_valid = req_valid[i];
        sel_tail  = req_tail[i];
        sel_flit  = req_flit[i*FLIT_W +: FLIT_W];
      end
    end
  end

  assign accept = (state_q == ST_LOCKED) && sel_valid && (credit_q != '0);

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (accept && (grant_q == GRANT_W'(i))) req_ready[i] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = pick;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (accept && sel_tail) begin
          state_d = ST_IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ov_d     = accept;
    flit_d   = accept ? sel_flit : flit_q;
    tail_d   = accept ? sel_tail : tail_q;
    credit_d = credit_q;
    err_d    = err_q;
    // A return at full count is an overflow: count saturates, error latches.
    if (accept && !credit_in) begin
      credit_d = credit_q - CW'(1);
    end else if (!accept && credit_in) begin
      if (credit_q == CW'(CREDITS)) err_d = 1'b1;
      else                          credit_d = credit_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      last_q   <= GRANT_W'(NUM_REQ - 1);
      credit_q <= CW'(CREDITS);
      err_q    <= 1'b0;
      ov_q     <= 1'b0;
      flit_q   <= '0;
      tail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      credit_q <= credit_d;
      err_q    <= err_d;
      ov_q     <= ov_d;
      flit_q   <= flit_d;
      tail_q   <= tail_d;
    end
  end

  assign out_valid  = ov_q;
  assign out_flit   = flit_q;
  assign out_tail   = tail_q;
  assign grant_id   = grant_q;
  assign locked     = (state_q == ST_LOCKED);
  assign credit_err = err_q;

endmodule
